// File: rtl/bitcoin_hash_host.sv
// Host-side memory owner and start/done sequencer for bitcoin_hash; optional macro BITCOIN_HASH_HOST_WR_FWD_EN selects write-first hasher reads.
// Latency: hash_start the cycle after the last message word; first result 2 cycles after hash_done; hasher reads 1 cycle.
// Backpressure: in_ready only in IDLE/LOAD; out_data/out_valid hold until out_ready, 1 word/cycle when out_ready stays high.
module bitcoin_hash_host #(
    parameter int DEPTH      = 64,
    parameter int MSG_ADDR   = 0,
    parameter int OUT_ADDR   = 32,
    parameter int MSG_WORDS  = 19,
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err,
    output logic        hash_start,
    input  logic        hash_done,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] MSG_BASE = AW'(MSG_ADDR);
    localparam logic [AW-1:0] OUT_BASE = AW'(OUT_ADDR);
    localparam logic [AW-1:0] MSG_LAST = AW'(MSG_WORDS - 1);
    localparam logic [AW-1:0] OUT_LAST = AW'(NUM_NONCES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] count;
    logic [AW-1:0] idx;
    logic [AW-1:0] rd_idx;
    logic          in_hs;
    logic          out_hs;
    logic          hasher_in_range;
    logic          hasher_wr_ok;
    logic          hasher_wr;
    logic [AW-1:0] hasher_idx;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    assign in_ready     = reset_n && (state == IDLE || state == LOAD);
    assign in_hs        = in_valid && in_ready;
    assign out_hs       = out_valid && out_ready;
    assign out_last     = out_valid && (idx == OUT_LAST);
    assign busy         = (state != IDLE);
    assign hash_start   = (state == START);
    assign message_addr = 16'(MSG_ADDR);
    assign output_addr  = 16'(OUT_ADDR);

    // Hasher port decode: writes only land while the hasher owns the memory.
    assign hasher_in_range = ({16'd0, mem_addr} < 32'(DEPTH));
    assign hasher_wr_ok    = (state == START || state == WAIT);
    assign hasher_wr       = mem_we && hasher_wr_ok && hasher_in_range;
    assign hasher_idx      = mem_addr[AW-1:0];

    // Host and hasher writes are state-exclusive, so one write port suffices.
    assign wr_en   = in_hs || hasher_wr;
    assign wr_addr = in_hs ? (MSG_BASE + ((state == IDLE) ? '0 : count)) : hasher_idx;
    assign wr_data = in_hs ? in_data : mem_write_data;

    // Drain prefetch: fetch the next word on a handshake so the stream never bubbles.
    assign rd_idx = out_hs ? (idx + AW'(1)) : idx;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_hs) state_nxt = (MSG_LAST == '0) ? START : LOAD;
            LOAD:    if (in_hs && count == MSG_LAST) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (hash_done) state_nxt = DRAIN;
            DRAIN:   if (out_hs && idx == OUT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Message word counter; the IDLE handshake writes word 0 and primes the count at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   count <= '0;
        else if (in_hs) count <= (state == IDLE) ? AW'(1) : count + AW'(1);
    end

    // Memory array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Hasher read port: registered, zero for out-of-range addresses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read_data <= '0;
        end else if (!hasher_in_range) begin
            mem_read_data <= '0;
        end else begin
`ifdef BITCOIN_HASH_HOST_WR_FWD_EN
            mem_read_data <= hasher_wr ? mem_write_data : mem[hasher_idx];
`else
            mem_read_data <= mem[hasher_idx];
`endif
        end
    end

    // Sticky error: misplaced hasher writes or any out-of-range hasher access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                       err <= 1'b0;
        else if ((mem_we && !hasher_wr_ok) || !hasher_in_range) err <= 1'b1;
    end

    // Result streaming: registered read of the current/next result word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            idx       <= '0;
        end else if (state == WAIT && hash_done) begin
            out_valid <= 1'b0;
            idx       <= '0;
        end else if (state == DRAIN) begin
            if (out_hs && idx == OUT_LAST) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                out_data  <= mem[OUT_BASE + rd_idx];
                if (out_hs) idx <= idx + AW'(1);
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitcoin_hash_host.sv
// Directed bench for bitcoin_hash_host: load, hasher memory access, drain, errors, reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Expected values are hand-computed constants.
module tb_bitcoin_hash_host;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err;
    logic        hash_start;
    logic        hash_done;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int nvec = 0;
    int nerr = 0;
    int k;

    bitcoin_hash_host dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .err            (err),
        .hash_start     (hash_start),
        .hash_done      (hash_done),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stream MSG_WORDS words base+i; optionally poke hash_done mid-load.
    task automatic load_msg(input logic [31:0] base, input bit inject_done);
        int nstart = 0;
        for (int i = 0; i < 19; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            step();
            nstart += int'(hash_start);
            if (i == 0) check("busy_first_word", 32'(busy), 32'd1);
            if (inject_done && i == 5) begin
                in_valid  = 1'b0;
                hash_done = 1'b1;
                step();
                hash_done = 1'b0;
                nstart += int'(hash_start);
                check("done_in_load_rdy", 32'(in_ready), 32'd1);
                check("done_in_load_valid", 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        check("start_after_last", 32'(hash_start), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        step();
        nstart += int'(hash_start);
        check("start_once", 32'(nstart), 32'd1);
    endtask

    // Hasher model: result j = base + j at OUT_ADDR + j.
    task automatic hasher_fill(input logic [31:0] base);
        for (int j = 0; j < 16; j++) begin
            mem_we         = 1'b1;
            mem_addr       = 16'(32 + j);
            mem_write_data = base + 32'(j);
            step();
        end
        mem_we   = 1'b0;
        mem_addr = 16'd0;
    endtask

    // hash_done then a full-rate drain with out_ready held high.
    task automatic drain_full(input logic [31:0] base);
        out_ready = 1'b1;
        hash_done = 1'b1;
        step();
        hash_done = 1'b0;
        check("drain_t1_valid", 32'(out_valid), 32'd0);
        for (int j = 0; j < 16; j++) begin
            step();
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data", out_data, base + 32'(j));
            check("drain_last", 32'(out_last), (j == 15) ? 32'd1 : 32'd0);
        end
        step();
        check("drain_end_valid", 32'(out_valid), 32'd0);
        check("drain_end_ready", 32'(in_ready), 32'd1);
        check("drain_end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        out_ready      = 1'b0;
        hash_done      = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        #1;
        // Reset values.
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_hash_start", 32'(hash_start), 32'd0);
        check("rst_rd_data", mem_read_data, 32'd0);
        check("message_addr", 32'(message_addr), 32'd0);
        check("output_addr", 32'(output_addr), 32'd32);
        step();
        step();
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Job 1: load with a stray hash_done in LOAD.
        load_msg(32'h0000_0000, 1'b1);
        check("wait_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 19; i++) begin
            mem_addr = 16'(i);
            step();
            check("msg_readback", mem_read_data, 32'(i));
        end

        // Hasher read latency: write mem[5], then read it back one edge later.
        mem_we = 1'b1; mem_addr = 16'd5; mem_write_data = 32'hDEAD_BEEF;
        step();
        mem_we = 1'b0;
        step();
        check("rd_latency", mem_read_data, 32'hDEAD_BEEF);

        // Same-cycle write/read at address 40.
        mem_we = 1'b1; mem_addr = 16'd40; mem_write_data = 32'h0BAD_F00D;
        step();
        mem_write_data = 32'h1234_5678;
        step();
`ifdef BITCOIN_HASH_HOST_WR_FWD_EN
        check("fwd_same_cycle", mem_read_data, 32'h1234_5678);
`else
        check("fwd_same_cycle", mem_read_data, 32'h0BAD_F00D);
`endif
        mem_we = 1'b0;
        step();
        check("fwd_write_done", mem_read_data, 32'h1234_5678);

        hasher_fill(32'hA000_0000);
        check("err_clean", 32'(err), 32'd0);

        // Out-of-range read in WAIT.
        mem_addr = 16'd64;
        step();
        check("oor_rd_data", mem_read_data, 32'd0);
        check("oor_err", 32'(err), 32'd1);
        mem_addr = 16'd0;

        // Drain with out_ready toggling 1,0,1,...
        out_ready = 1'b0;
        hash_done = 1'b1;
        step();
        hash_done = 1'b0;
        check("bp_t1_valid", 32'(out_valid), 32'd0);
        step();
        check("bp_t2_valid", 32'(out_valid), 32'd1);
        k = 0;
        for (int c = 0; c < 100 && k < 16; c++) begin
            bit was_valid;
            was_valid = out_valid;
            if (out_valid) begin
                check("bp_data", out_data, 32'hA000_0000 + 32'(k));
                check("bp_last", 32'(out_last), (k == 15) ? 32'd1 : 32'd0);
            end
            out_ready = (c % 2 == 0);
            step();
            if (was_valid && out_ready) k++;
        end
        check("bp_word_count", 32'(k), 32'd16);
        check("bp_end_valid", 32'(out_valid), 32'd0);
        check("bp_end_ready", 32'(in_ready), 32'd1);
        check("bp_end_busy", 32'(busy), 32'd0);

        // Job 2: full throughput.
        load_msg(32'h0000_0100, 1'b0);
        hasher_fill(32'hB000_0000);
        drain_full(32'hB000_0000);

        // Job 3: reset in the middle of DRAIN.
        load_msg(32'h0000_0200, 1'b0);
        hasher_fill(32'hC000_0000);
        out_ready = 1'b1;
        hash_done = 1'b1;
        step();
        hash_done = 1'b0;
        step();
        step();
        check("pre_rst_data", out_data, 32'hC000_0001);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_rd_data", mem_read_data, 32'd0);
        step();
        reset_n = 1'b1;
        #1;
        check("post_rst2_in_ready", 32'(in_ready), 32'd1);
        check("post_rst2_busy", 32'(busy), 32'd0);

        // Job 4: a fresh job after reset.
        load_msg(32'h0000_0300, 1'b0);
        mem_addr = 16'd18;
        step();
        check("job4_msg_last", mem_read_data, 32'h0000_0312);
        hasher_fill(32'hD000_0000);
        drain_full(32'hD000_0000);
        check("job4_err", 32'(err), 32'd0);

        // Hasher write in IDLE is dropped and flags err.
        mem_we = 1'b1; mem_addr = 16'd32; mem_write_data = 32'hFFFF_FFFF;
        step();
        mem_we = 1'b0;
        check("idle_we_err", 32'(err), 32'd1);
        step();
        check("idle_we_dropped", mem_read_data, 32'hD000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bitcoin_hash_host.md
# bitcoin_hash_host

Host-side counterpart to `bitcoin_hash`. It owns the word-addressed memory that the hasher reads its message from and writes its nonce hashes into. It also drives the hasher's start/done handshake. A host streams the message in over a valid/ready port; the block launches the hasher, waits for `done`, then streams the NUM_NONCES result words back out over a second valid/ready port.

## Interface
- DEPTH, 64: memory words; internal index width is clog2(DEPTH).
- MSG_ADDR, 0: word address of message word 0; also driven on `message_addr`.
- OUT_ADDR, 32: word address of result 0; also driven on `output_addr`.
- MSG_WORDS, 19: message words accepted per job.
- NUM_NONCES, 16: result words returned per job.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  host message word valid.
- in_ready  out  1  block accepts a message word.
- in_data  in  32  message word.
- out_valid  out  1  result word valid.
- out_ready  in  1  host accepts a result word.
- out_data  out  32  result word.
- out_last  out  1  marks the final result word (index NUM_NONCES-1).
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  sticky error flag; cleared only by reset.
- hash_start  out  1  one-cycle start pulse to the hasher.
- hash_done  in  1  hasher completion.
- message_addr  out  16  constant MSG_ADDR.
- output_addr  out  16  constant OUT_ADDR.
- mem_we  in  1  hasher write enable.
- mem_addr  in  16  hasher word address.
- mem_write_data  in  32  hasher write data.
- mem_read_data  out  32  registered read data to the hasher.

## Operation
- Memory is an internal array of DEPTH×32 words. The array is never reset.
- FSM states: IDLE, LOAD, START, WAIT, DRAIN.
- IDLE:
  - in_ready=1.
  - An in handshake writes mem[MSG_ADDR], sets word count to 1, and moves to LOAD.
  - If MSG_WORDS==1, it moves to START instead.
- LOAD:
  - in_ready=1.
  - Each handshake writes mem[MSG_ADDR+count] and increments count.
  - The handshake for word MSG_WORDS-1 moves to START.
- START: hash_start=1 for exactly this one cycle, then move to WAIT.
- WAIT: when hash_done is sampled high, move to DRAIN and set result index to 0.
- DRAIN:
  - out_data = mem[OUT_ADDR+idx].
  - A handshake increments idx.
  - The handshake at idx==NUM_NONCES-1 (out_last=1) moves to IDLE.
- Hasher memory port:
  - mem_read_data <= mem[mem_addr] every cycle, in every state (1-cycle read latency).
  - A write with mem_we=1 is performed only in START and WAIT.
  - A mem_we=1 in any other state is dropped and sets err.
- Out-of-range hasher addresses (mem_addr>=DEPTH):
  - Writes are dropped and set err.
  - Reads return 0 and set err.
- hash_done outside WAIT is ignored.
- in_valid outside IDLE/LOAD is not accepted (in_ready=0).
- Index arithmetic uses clog2(DEPTH) bits. MSG_ADDR+MSG_WORDS and OUT_ADDR+NUM_NONCES must each be <=DEPTH; there is no wrap-around.
- Host message writes and hasher writes never coincide, because the two are state-exclusive.

## Timing
- Reset values:
  - State IDLE; in_ready=1 after reset deassertion.
  - in_ready=0 while reset_n is low.
  - out_valid=0, out_data=0, out_last=0, busy=0, err=0, hash_start=0, mem_read_data=0.
- Reset mid-job (any state) returns to IDLE immediately. Partial message and result contents remain in memory, but the next job overwrites them.
- Last in handshake at cycle t:
  - hash_start=1 in cycle t+1.
  - busy stays high from t+1 (from t if the first word was accepted at t).
- hash_done sampled at edge t: out_valid=1 with result 0 at cycle t+2. This leaves one cycle for the registered read.
- DRAIN reads with a next-index address (idx+1 on handshake, else idx). This sustains 1 word/cycle with out_ready held high.
- Under backpressure, out_data and out_valid hold stable until the handshake.
- After the final handshake at edge t, out_valid=0 and in_ready=1 at t+1.

## Configuration
- Macro: BITCOIN_HASH_HOST_WR_FWD_EN.
- Defined: a hasher read of the address being written in the same cycle returns mem_write_data (write-first).
- Undefined: the same case returns the previous memory contents (read-first).
- Either way, the write completes.

## Test plan
- Load, defaults:
  - Stimulus: stream words 0x00000000..0x00000012 with in_valid held high.
  - Required: mem[0..18] matches the stream; hash_start pulses exactly once, the cycle after word 18; busy=1.
- Drain with backpressure:
  - Stimulus: hasher model writes mem[32+j]=0xA0000000+j; pulse hash_done; toggle out_ready 1,0,1,...
  - Required: out_data sequence 0xA0000000..0xA000000F with no repeats or skips; out_last only on 0xA000000F; then IDLE.
- Full throughput: with out_ready=1, first out_valid is 2 cycles after hash_done, and 16 words arrive on 16 consecutive cycles.
- Hasher read latency: preload mem[5]=0xDEADBEEF, drive mem_addr=5 at edge t; mem_read_data=0xDEADBEEF after edge t.
- Errors:
  - mem_we=1 in IDLE: write dropped, err=1.
  - mem_addr=64 read in WAIT: mem_read_data=0, err=1.
  - hash_done in LOAD: ignored, no state change.
- Reset and forwarding:
  - Assert reset_n=0 mid-DRAIN: outputs return to their reset values and state is IDLE; a new 19-word job then completes correctly.
  - Forwarding: same-cycle write 0x12345678 / read at address 40 returns 0x12345678 with BITCOIN_HASH_HOST_WR_FWD_EN defined, the old value without it.
